amba_slave_mem: RTL and testbench
=================================

// Module: amba_slave_mem
// PURPOSE
//  AHB-lite memory-mapped responder (slave) for the single-master AHB bus.
//  Pipelined address/data phases; byte/half/word access to an internal register array.
//  Programmable wait-state insertion via hready.
//  Bus target for the AHB master on the same clk/rst_n; hsel and hresp are not used (sole slave, always OKAY).
// PARAMETERS
//  DWIDTH       amba_pkg  data bus width; fixed 32 (4 byte lanes)
//  AWIDTH       amba_pkg  address bus width (byte address)
//  DEPTH        16        number of 32-bit words in the array; power of 2
//  WAIT_STATES  0         hready-low cycles inserted in every data phase (0..15)
// PORTS
//  clk     in   1       clock, rising edge
//  rst_n   in   1       asynchronous active-low reset
//  haddr   in   AWIDTH  byte address (address phase)
//  hwrite  in   1       1=write, 0=read (address phase)
//  hsize   in   3       0=byte, 1=half, 2=word; others unsupported
//  htrans  in   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwdata  in   DWIDTH  write data (data phase); master replicates narrow data on all lanes
//  hready  out  1       1=data phase completes this cycle / slave can accept an address
//  hrdata  out  DWIDTH  read data; valid when hready=1 in a read data phase
// BEHAVIOUR
//  Reset: hready=1, hrdata=0, FSM=ST_IDLE, wait counter=0, no pending transfer; array contents undefined.
//  Address accept: on a rising edge with hready=1 and htrans[1]=1 (NONSEQ/SEQ), latch haddr, hwrite, hsize.
//   IDLE/BUSY, or hready=0: nothing is latched.
//  FSM:
//   ST_IDLE: hready=1. Accept -> ST_WAIT (cnt=WAIT_STATES) if WAIT_STATES>0, else ST_DATA.
//   ST_WAIT: hready=0; cnt decrements each cycle; cnt==1 -> ST_DATA. Bus inputs are ignored (master holds them).
//   ST_DATA: hready=1; the pending transfer completes on this edge.
//    Simultaneous accept of the next address -> ST_WAIT/ST_DATA as from ST_IDLE; otherwise -> ST_IDLE.
//  Latency: WAIT_STATES=0 -> data phase is the cycle after the address phase (back-to-back, full throughput).
//   N>0 -> N hready-low cycles, then one hready-high cycle.
//  Word index = latched addr[2+$clog2(DEPTH)-1:2]; upper bits are ignored (addresses alias/wrap modulo DEPTH*4).
//  Write: committed on the edge ending the data phase (ST_DATA). Byte enables come from latched hsize/addr[1:0]:
//   byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1} (addr[0] ignored); word -> all lanes (addr[1:0] ignored).
//   Each enabled lane takes hwdata from the same lane.
//  Read: hrdata = full stored word at the latched index (all lanes, unmasked), driven while in ST_DATA.
//   hrdata holds its last value otherwise.
//  Read-after-write, back-to-back same address: the read data phase follows the write commit edge, so the new value is returned. No forwarding path needed.
//  Unsupported hsize (3..7): transfer completes with normal timing; no write; hrdata=0.
//  Reset mid-transfer: pending write is dropped (array word unchanged); FSM -> ST_IDLE, hready=1.
// STRUCTURE
//  amba_pkg additions:
//   htrans_t enum (HTRANS_IDLE/BUSY/NONSEQ/SEQ)
//   hsize_t constants (HSIZE_BYTE/HALF/WORD)
//   slv_state_t enum (ST_IDLE/ST_WAIT/ST_DATA)
//   function be_from_size(hsize, addr[1:0]) -> [3:0] byte enables
//  Sub-module amba_be_ram: DEPTH x 32 array; inputs: 4-bit byte-enable write port; output: combinational read port.
//  Top holds the FSM, wait counter and address/control latch.
// TESTING
//  1 Reset, WAIT_STATES=0: hready=1, hrdata=0 during and after rst_n low.
//  2 Word write 0xDEADBEEF @0x08, then read @0x08 back-to-back:
//    hready stays 1; hrdata=0xDEADBEEF in the read data phase.
//  3 Byte writes 0x11,0x22,0x33,0x44 (replicated ×4) to 0x10..0x13, then word read @0x10 -> 0x44332211.
//    Half write 0xABCD @0x12 -> 0xABCD2211.
//  4 WAIT_STATES=3, read @0x08: exactly 3 cycles hready=0, then 1 cycle hready=1 with data.
//    Address changes during the wait cycles are ignored.
//  5 htrans IDLE/BUSY with hwrite=1 -> no array change, FSM stays ST_IDLE.
//    hsize=3 write -> no change; read -> hrdata=0.
//  6 DEPTH=16: write @0x40 aliases to word 0 (read @0x00 returns it).
//    rst_n pulsed during a write's wait states -> word unchanged, hready=1.

Source files
------------

// File: rtl/amba_pkg.sv
// amba_pkg: shared AHB-lite types, bus widths and byte-enable helpers.
//   DWIDTH / AWIDTH : data and byte-address bus widths
//   htrans_t        : transfer type encoding
//   HSIZE_*         : supported transfer sizes
//   slv_state_t     : responder FSM states
//   be_from_size()  : lane enables for a transfer size and address offset
//   size_ok()       : 1 when the transfer size is one the responder stores/returns
package amba_pkg;

   localparam int DWIDTH = 32;
   localparam int AWIDTH = 32;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DATA = 2'd2
   } slv_state_t;

   // Unsupported sizes produce no lane enables, so they never write.
   function automatic logic [3:0] be_from_size(input logic [2:0] hsize, input logic [1:0] addr);
      logic [3:0] be;
      be = 4'b0000;
      case (hsize)
         HSIZE_BYTE: be = 4'b0001 << addr;
         HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic size_ok(input logic [2:0] hsize);
      logic ok;
      case (hsize)
         HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/amba_be_ram.sv
// amba_be_ram: DEPTH x 32-bit storage with a byte-lane-masked write port
// and a combinational read port. Contents are not reset.
//   clk   : write clock
//   we    : write strobe
//   be    : per-lane write enables (lane 0 = bits 7:0)
//   waddr : write word index
//   wdata : write data, lane n taken from bits 8n+7:8n
//   raddr : read word index
//   rdata : stored word at raddr (combinational)
module amba_be_ram
   import amba_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [IW-1:0]     waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic [IW-1:0]     raddr,
   output logic [DWIDTH-1:0] rdata
);

   logic [DWIDTH-1:0] mem_r [DEPTH];

   // Lane-masked write; unenabled lanes keep their previous contents.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we && be[b]) begin
            mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/amba_slave_mem.sv
// amba_slave_mem: AHB-lite memory responder with programmable wait states.
// Sole slave on the bus, so there is no hsel and every response is OKAY.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   haddr      : byte address (address phase)
//   hwrite     : 1 = write, 0 = read (address phase)
//   hsize      : 0 byte, 1 half, 2 word; larger sizes complete but do nothing
//   htrans     : IDLE/BUSY ignored, NONSEQ/SEQ start a transfer
//   hwdata     : write data (data phase), narrow data replicated on all lanes
//   hready     : low during inserted wait cycles, high otherwise
//   hrdata     : read data, valid while hready=1 in a read data phase
module amba_slave_mem
   import amba_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AWIDTH-1:0] haddr,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [1:0]        htrans,
   input  logic [DWIDTH-1:0] hwdata,
   output logic              hready,
   output logic [DWIDTH-1:0] hrdata
);

   localparam int         IW       = $clog2(DEPTH);
   localparam logic [3:0] WS_INIT  = 4'(WAIT_STATES);
   localparam logic       HAS_WAIT = (WAIT_STATES > 0);

   slv_state_t        state_r, state_s;
   logic [3:0]        cnt_r, cnt_s;
   logic [IW+1:0]     addr_r;
   logic              write_r;
   logic [2:0]        size_r;
   logic [DWIDTH-1:0] hrdata_r;

   logic              hready_s;
   logic              accept_s;
   logic              data_s;
   logic              rd_phase_s;
   logic [3:0]        be_s;
   logic [DWIDTH-1:0] ram_rdata_s;
   logic [DWIDTH-1:0] rd_word_s;

   assign hready_s   = (state_r != ST_WAIT);
   assign accept_s   = hready_s & htrans[1];
   assign data_s     = (state_r == ST_DATA);
   assign rd_phase_s = data_s & ~write_r;
   assign be_s       = be_from_size(size_r, addr_r[1:0]);

   // Next-state and wait-counter logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE, ST_DATA: begin
            if (accept_s && HAS_WAIT) begin
               state_s = ST_WAIT;
               cnt_s   = WS_INIT;
            end else if (accept_s) begin
               state_s = ST_DATA;
               cnt_s   = 4'd0;
            end else begin
               state_s = ST_IDLE;
               cnt_s   = 4'd0;
            end
         end
         ST_WAIT: begin
            cnt_s = cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_WAIT;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Address-phase latch; only updated when a transfer is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r  <= '0;
         write_r <= 1'b0;
         size_r  <= 3'd0;
      end else if (accept_s) begin
         addr_r  <= haddr[IW+1:0];
         write_r <= hwrite;
         size_r  <= hsize;
      end
   end

   // Upper address bits are dropped, so the array aliases every DEPTH*4 bytes.
   amba_be_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (data_s & write_r),
      .be    (be_s),
      .waddr (addr_r[IW+1:2]),
      .wdata (hwdata),
      .raddr (addr_r[IW+1:2]),
      .rdata (ram_rdata_s)
   );

   assign rd_word_s = size_ok(size_r) ? ram_rdata_s : '0;

   // Remember the last returned read word so hrdata holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hrdata_r <= '0;
      end else if (rd_phase_s) begin
         hrdata_r <= rd_word_s;
      end
   end

   // The read word is taken straight from the array during the data phase so a
   // write committed on the preceding edge is already visible.
   assign hrdata = rd_phase_s ? rd_word_s : hrdata_r;
   assign hready = hready_s;

endmodule

// File: tb/tb_amba_slave_mem.sv
// tb_amba_slave_mem: drives two responders (0 and 3 wait states) with a
// pipelined AHB-lite master and checks read data through a scoreboard queue.
module tb_amba_slave_mem;
   import amba_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] haddr  [2];
   logic        hwrite [2];
   logic [2:0]  hsize  [2];
   logic [1:0]  htrans [2];
   logic [31:0] hwdata [2];
   logic        hready [2];
   logic [31:0] hrdata [2];

   logic [31:0] pend   [2];
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic        dph_act [2];
   logic        dph_rd  [2];
   int          wcnt    [2];
   int          n_checks;
   int          n_pass;

   amba_slave_mem #(.DEPTH(16), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .haddr(haddr[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
      .htrans(htrans[0]), .hwdata(hwdata[0]), .hready(hready[0]), .hrdata(hrdata[0])
   );

   amba_slave_mem #(.DEPTH(16), .WAIT_STATES(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .haddr(haddr[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
      .htrans(htrans[1]), .hwdata(hwdata[1]), .hready(hready[1]), .hrdata(hrdata[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Protocol tracker: which instance currently has a data phase, and whether it is a read.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            dph_act[i] <= 1'b0;
            dph_rd[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (hready[i]) begin
               dph_act[i] <= htrans[i][1];
               dph_rd[i]  <= htrans[i][1] & ~hwrite[i];
            end
         end
      end
   end

   // Monitor: count wait cycles per data phase and pop expected read data on completion.
   always @(negedge clk) begin
      if (!rst_n) begin
         wcnt[0] = 0;
         wcnt[1] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (dph_act[i]) begin
               if (!hready[i]) begin
                  wcnt[i]++;
               end else begin
                  check_val(i == 0 ? "waits0" : "waits1", 32'(wcnt[i]), (i == 0) ? 32'd0 : 32'd3);
                  wcnt[i] = 0;
                  if (dph_rd[i]) begin
                     if (i == 0) begin
                        if (q0.size() == 0) check_val("sb_empty0", 32'd1, 32'd0);
                        else                check_val("rdata0", hrdata[0], q0.pop_front());
                     end else begin
                        if (q1.size() == 0) check_val("sb_empty1", 32'd1, 32'd0);
                        else                check_val("rdata1", hrdata[1], q1.pop_front());
                     end
                  end
               end
            end
         end
      end
   end

   // One address phase; wd is the data driven in this transfer's data phase.
   // With scr set, the address/control lines are scrambled while hready is low.
   task automatic bus(input int i, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] ad, input logic [31:0] wd, input logic scr);
      int   n;
      logic rdy;
      hwdata[i] = pend[i];
      pend[i]   = wd;
      n         = 0;
      rdy       = 1'b0;
      while (!rdy && n < 40) begin
         rdy = hready[i];
         if (rdy || !scr) begin
            htrans[i] = tr; hwrite[i] = wr; hsize[i] = sz; haddr[i] = ad;
         end else begin
            htrans[i] = HTRANS_NONSEQ; hwrite[i] = 1'b1; hsize[i] = HSIZE_WORD; haddr[i] = ad ^ 32'h0000_0018;
         end
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (!rdy) check_val("bus_timeout", 32'd0, 32'd1);
   endtask

   task automatic wr(input int i, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] d);
      bus(i, HTRANS_NONSEQ, 1'b1, sz, ad, d, 1'b0);
   endtask

   task automatic rd(input int i, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] exp);
      if (i == 0) q0.push_back(exp);
      else        q1.push_back(exp);
      bus(i, HTRANS_NONSEQ, 1'b0, sz, ad, 32'h0, 1'b0);
   endtask

   task automatic flush(input int i, input logic scr);
      bus(i, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, scr);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      for (int i = 0; i < 2; i++) begin
         haddr[i] = 32'h0; hwrite[i] = 1'b0; hsize[i] = 3'd0; htrans[i] = HTRANS_IDLE;
         hwdata[i] = 32'h0; pend[i] = 32'h0;
      end

      // Reset values, during and after reset.
      repeat (3) @(negedge clk);
      check_val("rst_hready0", 32'(hready[0]), 32'd1);
      check_val("rst_hready1", 32'(hready[1]), 32'd1);
      check_val("rst_hrdata0", hrdata[0], 32'h0);
      check_val("rst_hrdata1", hrdata[1], 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_hready0", 32'(hready[0]), 32'd1);
      check_val("post_rst_hrdata0", hrdata[0], 32'h0);

      // Back-to-back word write then read, no wait states.
      wr(0, HSIZE_WORD, 32'h08, 32'hDEADBEEF);
      rd(0, HSIZE_WORD, 32'h08, 32'hDEADBEEF);
      flush(0, 1'b0);
      check_val("hold_hrdata0", hrdata[0], 32'hDEADBEEF);

      // Byte lanes, then a half-word overwrite.
      wr(0, HSIZE_BYTE, 32'h10, 32'h11111111);
      wr(0, HSIZE_BYTE, 32'h11, 32'h22222222);
      wr(0, HSIZE_BYTE, 32'h12, 32'h33333333);
      wr(0, HSIZE_BYTE, 32'h13, 32'h44444444);
      rd(0, HSIZE_WORD, 32'h10, 32'h44332211);
      wr(0, HSIZE_HALF, 32'h12, 32'hABCDABCD);
      rd(0, HSIZE_WORD, 32'h10, 32'hABCD2211);
      flush(0, 1'b0);

      // IDLE/BUSY with hwrite high must not write; unsupported size does nothing.
      bus(0, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h08, 32'hFFFFFFFF, 1'b0);
      check_val("idle_hready", 32'(hready[0]), 32'd1);
      bus(0, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h08, 32'hFFFFFFFF, 1'b0);
      check_val("busy_hready", 32'(hready[0]), 32'd1);
      bus(0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b0);
      wr(0, 3'd3, 32'h08, 32'h12345678);
      rd(0, HSIZE_WORD, 32'h08, 32'hDEADBEEF);
      rd(0, 3'd3, 32'h08, 32'h00000000);
      flush(0, 1'b0);

      // Address aliasing modulo DEPTH*4.
      wr(0, HSIZE_WORD, 32'h40, 32'hCAFEF00D);
      rd(0, HSIZE_WORD, 32'h00, 32'hCAFEF00D);
      flush(0, 1'b0);

      // Three wait states; bus lines scrambled during the read's waits.
      wr(1, HSIZE_WORD, 32'h08, 32'h600DF00D);
      flush(1, 1'b0);
      rd(1, HSIZE_WORD, 32'h08, 32'h600DF00D);
      flush(1, 1'b1);
      wr(1, HSIZE_WORD, 32'h0C, 32'h00000001);
      rd(1, HSIZE_WORD, 32'h0C, 32'h00000001);
      rd(1, HSIZE_WORD, 32'h08, 32'h600DF00D);
      flush(1, 1'b0);

      // Reset during a write's wait states drops the write.
      wr(1, HSIZE_WORD, 32'h20, 32'h0BADF00D);
      flush(1, 1'b0);
      bus(1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h5555AAAA, 1'b0);
      htrans[1] = HTRANS_IDLE;
      hwdata[1] = pend[1];
      pend[1]   = 32'h0;
      @(negedge clk);
      check_val("wait_hready1", 32'(hready[1]), 32'd0);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_hready1", 32'(hready[1]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_mid_hready1", 32'(hready[1]), 32'd1);
      rd(1, HSIZE_WORD, 32'h20, 32'h0BADF00D);
      flush(1, 1'b0);

      check_val("sb_left0", 32'(q0.size()), 32'd0);
      check_val("sb_left1", 32'(q1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
